// File: rtl/address_generator.sv
// Address generator for one fully-connected layer of Nk inputs by Nk neurons.
// Each RUN cycle issues one weight address and one input-neuron address; the
// output-neuron write address is valid while neuron_finished is high.
// Addresses are base + offset with 8-bit wrap. The weight offset j*Nk+i is
// kept as a running count, so no multiplier is needed.
module address_generator (
  input  logic       clk,
  input  logic       reset,
  input  logic       read,
  input  logic [7:0] Nk,
  input  logic [7:0] read_weight_base_addr,
  input  logic [7:0] read_neuro_base_addr,
  input  logic [7:0] write_neuro_base_addr,
  output logic [7:0] weight_read_addr,
  output logic [7:0] neuro_read_addr,
  output logic [7:0] neuro_write_addr,
  output logic       neuron_finished,
  output logic       finished
);

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_r;
  logic [7:0] nk_r;
  logic [7:0] wb_r;
  logic [7:0] rb_r;
  logic [7:0] wrb_r;
  logic [7:0] i_r;
  logic [7:0] j_r;
  logic [7:0] woff_r;

  logic [7:0] nk_last_s;
  logic       last_i_s;
  logic       last_j_s;

  // Last-index detection for the input and neuron counters.
  always_comb begin
    nk_last_s = nk_r - 8'd1;
    last_i_s  = (i_r == nk_last_s);
    last_j_s  = (j_r == nk_last_s);
  end

  // Layer sequencer: config capture while armed, counter stepping in RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ARM;
      nk_r    <= 8'd0;
      wb_r    <= 8'd0;
      rb_r    <= 8'd0;
      wrb_r   <= 8'd0;
      i_r     <= 8'd0;
      j_r     <= 8'd0;
      woff_r  <= 8'd0;
    end else if (read) begin
      // Keep tracking the config while armed; the last value before read
      // falls is the one the layer runs with.
      state_r <= ARM;
      nk_r    <= Nk;
      wb_r    <= read_weight_base_addr;
      rb_r    <= read_neuro_base_addr;
      wrb_r   <= write_neuro_base_addr;
      i_r     <= 8'd0;
      j_r     <= 8'd0;
      woff_r  <= 8'd0;
    end else begin
      case (state_r)
        ARM: begin
          if (nk_r == 8'd0) begin
            state_r <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        RUN: begin
          if (last_i_s) begin
            if (last_j_s) begin
              // Final input of final neuron: freeze counters for DONE.
              state_r <= DONE;
            end else begin
              i_r    <= 8'd0;
              j_r    <= j_r + 8'd1;
              woff_r <= woff_r + 8'd1;
            end
          end else begin
            i_r    <= i_r + 8'd1;
            woff_r <= woff_r + 8'd1;
          end
        end
        DONE: begin
          state_r <= DONE;
        end
        default: begin
          state_r <= ARM;
        end
      endcase
    end
  end

  // Address and flag decode from the registered state.
  always_comb begin
    weight_read_addr = wb_r + woff_r;
    neuro_read_addr  = rb_r + i_r;
    neuro_write_addr = wrb_r + j_r;
    if (state_r == RUN) begin
      neuron_finished = last_i_s;
    end else begin
      neuron_finished = 1'b0;
    end
    if (state_r == DONE) begin
      finished = 1'b1;
    end else begin
      finished = 1'b0;
    end
  end

endmodule

// File: tb/tb_address_generator.sv
// Self-checking bench for address_generator. Expected outputs come from a
// closed-form model: RUN cycle k of a layer of size nk has weight offset k,
// input index k mod nk and neuron index k div nk.
module tb_address_generator;

  logic       clk = 1'b0;
  logic       reset;
  logic       read;
  logic [7:0] Nk;
  logic [7:0] rwb;
  logic [7:0] rnb;
  logic [7:0] wnb;
  logic [7:0] weight_read_addr;
  logic [7:0] neuro_read_addr;
  logic [7:0] neuro_write_addr;
  logic       neuron_finished;
  logic       finished;

  int checks = 0;
  int errors = 0;

  logic [25:0] obs;
  assign obs = {weight_read_addr, neuro_read_addr, neuro_write_addr,
                neuron_finished, finished};

  address_generator dut (
    .clk                   (clk),
    .reset                 (reset),
    .read                  (read),
    .Nk                    (Nk),
    .read_weight_base_addr (rwb),
    .read_neuro_base_addr  (rnb),
    .write_neuro_base_addr (wnb),
    .weight_read_addr      (weight_read_addr),
    .neuro_read_addr       (neuro_read_addr),
    .neuro_write_addr      (neuro_write_addr),
    .neuron_finished       (neuron_finished),
    .finished              (finished)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Expected outputs for RUN cycle k (0-based).
  function automatic logic [25:0] model_run(int nk, int wb, int rb, int wrb, int k);
    logic [7:0] w, r, o;
    logic       nf;
    w  = 8'((wb + k) % 256);
    r  = 8'((rb + (k % nk)) % 256);
    o  = 8'((wrb + (k / nk)) % 256);
    nf = ((k % nk) == (nk - 1));
    return {w, r, o, nf, 1'b0};
  endfunction

  // Expected outputs once the layer is complete.
  function automatic logic [25:0] model_done(int nk, int wb, int rb, int wrb);
    logic [7:0] w, r, o;
    if (nk == 0) begin
      w = 8'(wb); r = 8'(rb); o = 8'(wrb);
    end else begin
      w = 8'((wb + nk * nk - 1) % 256);
      r = 8'((rb + nk - 1) % 256);
      o = 8'((wrb + nk - 1) % 256);
    end
    return {w, r, o, 1'b0, 1'b1};
  endfunction

  // Hold read high for one edge with the given config, check ARM, then release.
  task automatic arm_layer(input int nk, input int wb, input int rb, input int wrb);
    @(negedge clk);
    read = 1'b1; Nk = 8'(nk); rwb = 8'(wb); rnb = 8'(rb); wnb = 8'(wrb);
    @(negedge clk);
    checks++;
    if (obs !== {8'(wb), 8'(rb), 8'(wrb), 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL arm: got %h expected %h", obs, {8'(wb), 8'(rb), 8'(wrb), 2'b00});
    end
    read = 1'b0;
    Nk = 8'($urandom); rwb = 8'($urandom); rnb = 8'($urandom); wnb = 8'($urandom);
  endtask

  // Check ncyc RUN cycles against the model, scrambling config (must be ignored).
  task automatic run_layer(input int nk, input int wb, input int rb, input int wrb,
                           input int ncyc, output int pulses);
    logic [25:0] e;
    pulses = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      e = model_run(nk, wb, rb, wrb, k);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL run nk=%0d k=%0d: got %h expected %h", nk, k, obs, e);
      end
      if (neuron_finished === 1'b1) pulses++;
      Nk = 8'($urandom); rwb = 8'($urandom);
    end
  endtask

  // Check that DONE is reached and held for hold cycles.
  task automatic check_done(input int nk, input int wb, input int rb, input int wrb,
                            input int hold);
    logic [25:0] e;
    e = model_done(nk, wb, rb, wrb);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL done nk=%0d h=%0d: got %h expected %h", nk, h, obs, e);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; read = 1'b1; Nk = 8'd3; rwb = 8'd1; rnb = 8'd2; wnb = 8'd3;
    #12;
    checks++;
    if (obs !== 26'd0) begin
      errors++;
      $display("FAIL reset: got %h expected %h", obs, 26'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== {8'd1, 8'd2, 8'd3, 2'b00}) begin
      errors++;
      $display("FAIL reset_arm: got %h expected %h", obs, {8'd1, 8'd2, 8'd3, 2'b00});
    end
  endtask

  // Nk moves 3 -> 4 while armed; the run must be 16 cycles long.
  task automatic test_config_tracking;
    int p;
    Nk = 8'd4;
    @(negedge clk);
    read = 1'b0;
    run_layer(4, 1, 2, 3, 16, p);
    checks++;
    if (p !== 4) begin
      errors++;
      $display("FAIL track_pulses: got %0d expected %0d", p, 4);
    end
    check_done(4, 1, 2, 3, 3);
  endtask

  task automatic test_nominal;
    int p;
    arm_layer(4, 1, 2, 3);
    run_layer(4, 1, 2, 3, 16, p);
    checks++;
    if (p !== 4) begin
      errors++;
      $display("FAIL nominal_pulses: got %0d expected %0d", p, 4);
    end
    @(negedge clk);
    checks++;
    if (obs !== {8'd16, 8'd5, 8'd6, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL nominal_final: got %h expected %h", obs, {8'd16, 8'd5, 8'd6, 2'b01});
    end
  endtask

  task automatic test_wrap;
    int p;
    arm_layer(4, 250, 254, 253);
    run_layer(4, 250, 254, 253, 16, p);
    check_done(4, 250, 254, 253, 2);
  endtask

  task automatic test_nk_zero_and_one;
    int p;
    arm_layer(0, 9, 8, 7);
    check_done(0, 9, 8, 7, 4);
    arm_layer(1, 5, 6, 7);
    run_layer(1, 5, 6, 7, 1, p);
    checks++;
    if (p !== 1) begin
      errors++;
      $display("FAIL nk1_pulses: got %0d expected %0d", p, 1);
    end
    check_done(1, 5, 6, 7, 2);
  endtask

  task automatic test_restart;
    int p;
    arm_layer(4, 10, 20, 30);
    run_layer(4, 10, 20, 30, 6, p);
    arm_layer(3, 40, 50, 60);
    run_layer(3, 40, 50, 60, 9, p);
    checks++;
    if (p !== 3) begin
      errors++;
      $display("FAIL restart_pulses: got %0d expected %0d", p, 3);
    end
    check_done(3, 40, 50, 60, 2);
  endtask

  task automatic test_reset_mid_run;
    int p;
    arm_layer(5, 100, 110, 120);
    run_layer(5, 100, 110, 120, 7, p);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs !== 26'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", obs, 26'd0);
    end
    @(negedge clk);
    read = 1'b1; Nk = 8'd2; rwb = 8'd7; rnb = 8'd8; wnb = 8'd9;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== {8'd7, 8'd8, 8'd9, 2'b00}) begin
      errors++;
      $display("FAIL rearm_after_reset: got %h expected %h", obs, {8'd7, 8'd8, 8'd9, 2'b00});
    end
    read = 1'b0;
    run_layer(2, 7, 8, 9, 4, p);
    check_done(2, 7, 8, 9, 1);
  endtask

  task automatic test_random;
    int nk, wb, rb, wrb, p;
    for (int n = 0; n < 12; n++) begin
      nk  = int'($urandom_range(1, 8));
      wb  = int'($urandom_range(0, 255));
      rb  = int'($urandom_range(0, 255));
      wrb = int'($urandom_range(0, 255));
      arm_layer(nk, wb, rb, wrb);
      run_layer(nk, wb, rb, wrb, nk * nk, p);
      checks++;
      if (p !== nk) begin
        errors++;
        $display("FAIL random_pulses: got %0d expected %0d", p, nk);
      end
      check_done(nk, wb, rb, wrb, 2);
    end
  endtask

  // Test sequence.
  initial begin
    test_reset;
    test_config_tracking;
    test_nominal;
    test_wrap;
    test_nk_zero_and_one;
    test_restart;
    test_reset_mid_run;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/address_generator.md
Name: address_generator

Overview:
Generates RAM addresses for evaluating one fully-connected neural-network layer of Nk inputs by Nk neurons. Each RUN cycle issues one weight address and one input-neuron address. One output-neuron write address is issued per neuron. The block sits between the layer controller (which arms it via read) and the weight/neuron RAMs plus the MAC datapath. neuron_finished tells the MAC to store its result; finished tells the controller the layer is done.

Parameters:
none (all widths fixed at 8 bits)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
read  input  1  arm/load: high = capture config and hold at start; low = run
Nk  input  8  layer size (inputs per neuron = neurons in layer)
read_weight_base_addr  input  8  weight RAM base address
read_neuro_base_addr  input  8  input-neuron RAM base address
write_neuro_base_addr  input  8  output-neuron RAM base address
weight_read_addr  output  8  current weight address
neuro_read_addr  output  8  current input-neuron address
neuro_write_addr  output  8  current output-neuron address
neuron_finished  output  1  high during the last input cycle of the current neuron
finished  output  1  layer complete, held high

Behaviour:
- Internal state:
  - registers nk, wb, rb, wrb (latched config)
  - counters i (input index) and j (neuron index)
  - running weight offset woff = j*Nk+i, kept incrementally (no multiplier)
  - states ARM, RUN, DONE
- reset low (async): state ARM; i=j=woff=0; nk/wb/rb/wrb cleared; all outputs 0.
- read high at a clock edge (any state, highest priority after reset):
  - latch Nk and the three bases
  - clear i, j, woff
  - state ARM
  - Config changes while read is high are tracked; the last value before read falls is used.
- ARM with read low: if nk==0, go to DONE; else go to RUN.
- RUN, each cycle:
  - i, woff increment
  - when i==nk-1: i<=0, j increments
  - when additionally j==nk-1: go to DONE and freeze counters at their final values
  - Config inputs are ignored while running.
- DONE: holds until read high or reset.
- Output address formulas (combinational from registers, 8-bit modulo-256 wrap, carries discarded):
  - weight_read_addr = wb + woff
  - neuro_read_addr = rb + i
  - neuro_write_addr = wrb + j
- Output values outside RUN: in ARM the addresses equal the latched bases. In DONE they show the final pair (i=nk-1, j=nk-1).
- neuron_finished = (state==RUN) && (i==nk-1). It is one cycle wide per neuron, and neuro_write_addr is valid in that cycle.
- finished = (state==DONE); it is 0 in ARM and RUN.
- Total RUN length: nk*nk cycles. finished rises on the edge after the last RUN cycle.
- read asserted mid-RUN restarts cleanly at the next edge; no partial neuron_finished.
- reset mid-operation clears everything immediately, asynchronously.

Test Plan:
- Reset and arm: reset low, then high with read=1, Nk=3, bases 1/2/3 → all outputs 0 during reset; in ARM the addresses are 1/2/3 and both flags are 0.
- Config tracking while armed: Nk changed 3→4 while read=1, then read dropped → run uses nk=4, giving 16 RUN cycles.
- Nominal layer, Nk=4, bases 1/2/3:
  - weight_read_addr steps 1..16
  - neuro_read_addr cycles 2,3,4,5
  - neuro_write_addr holds 3,4,5,6 per neuron
  - neuron_finished pulses on RUN cycles 4, 8, 12, 16
  - finished goes high after cycle 16 and holds, with addresses frozen at 16/5/6
- Wrap: wb=250, Nk=4 → weight addresses 250..255, then 0..9, with no error flag.
- Nk=0 → ARM goes straight to DONE; finished=1, neuron_finished never pulses.
- Restart and reset: read pulsed high mid-run → counters restart at the bases. reset low mid-run → outputs 0 immediately, without waiting for a clock edge.
